// File: rtl/router_switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
// master drives requests and downstream on/off; slave is the allocator.
interface router_switch_allocator_if #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned IDX_W     = 3
);
  logic [NUM_PORTS-1:0]       i_req_valid;
  logic [NUM_PORTS*IDX_W-1:0] i_req_dst;
  logic [NUM_PORTS-1:0]       i_req_head;
  logic [NUM_PORTS-1:0]       i_req_tail;
  logic [NUM_PORTS-1:0]       i_on_off;
  logic [NUM_PORTS-1:0]       o_grant;
  logic [NUM_PORTS-1:0]       o_xbar_valid;
  logic [NUM_PORTS*IDX_W-1:0] o_xbar_sel;
  logic [NUM_PORTS-1:0]       o_locked;
  logic                       o_proto_err;

  modport master (
    output i_req_valid, i_req_dst, i_req_head, i_req_tail, i_on_off,
    input  o_grant, o_xbar_valid, o_xbar_sel, o_locked, o_proto_err
  );

  modport slave (
    input  i_req_valid, i_req_dst, i_req_head, i_req_tail, i_on_off,
    output o_grant, o_xbar_valid, o_xbar_sel, o_locked, o_proto_err
  );
endinterface

// File: rtl/router_switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among head flits for a free output,
// then the output stays locked to its owner until the tail flit crosses.
module router_switch_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned IDX_W     = 3
) (
  input logic                       clk,
  input logic                       reset,
  router_switch_allocator_if.slave  bus
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e           state_q  [NUM_PORTS];
  state_e           state_d  [NUM_PORTS];
  logic [IDX_W-1:0] owner_q  [NUM_PORTS];
  logic [IDX_W-1:0] owner_d  [NUM_PORTS];
  logic [IDX_W-1:0] rr_ptr_q [NUM_PORTS];
  logic [IDX_W-1:0] rr_ptr_d [NUM_PORTS];
  logic             err_q, err_d;

  logic [IDX_W-1:0]           req_dst [NUM_PORTS];
  logic [NUM_PORTS-1:0]       grant;
  logic [NUM_PORTS-1:0]       xbar_valid;
  logic [NUM_PORTS*IDX_W-1:0] xbar_sel;

  // Pointer increment wraps at NUM_PORTS, not at 2^IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
    if (32'(p) + 32'd1 >= NUM_PORTS) return '0;
    return p + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign req_dst[g]     = bus.i_req_dst[g*IDX_W +: IDX_W];
    assign bus.o_locked[g] = (state_q[g] == StLocked);
  end

  always_comb begin
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] body;
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     own;
    int unsigned          idx;

    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q;
    grant      = '0;
    xbar_valid = '0;
    xbar_sel   = '0;
    cand       = '0;
    body       = '0;
    found      = 1'b0;
    win        = '0;
    own        = '0;
    idx        = 0;

    for (int o = 0; o < NUM_PORTS; o++) begin
      cand  = '0;
      body  = '0;
      found = 1'b0;
      win   = '0;
      own   = owner_q[o];
      // Out-of-range destinations never match any o, so they drop out here.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (bus.i_req_valid[i] && req_dst[i] == IDX_W'(o)) begin
          if (bus.i_req_head[i]) cand[i] = 1'b1;
          else                   body[i] = 1'b1;
        end
      end

      case (state_q[o])
        StIdle: begin
          if (|body) err_d = 1'b1;
          if (bus.i_on_off[o]) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
              idx = 32'(rr_ptr_q[o]) + 32'(k);
              if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
              if (!found && cand[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
              end
            end
          end
          if (found) begin
            grant[win]                  = 1'b1;
            xbar_valid[o]               = 1'b1;
            xbar_sel[o*IDX_W +: IDX_W]  = win;
            if (bus.i_req_tail[win]) begin
              rr_ptr_d[o] = wrap_inc(win);
            end else begin
              state_d[o] = StLocked;
              owner_d[o] = win;
            end
          end
        end
        StLocked: begin
          if (bus.i_req_valid[own] && req_dst[own] == IDX_W'(o) && bus.i_on_off[o]) begin
            grant[own]                 = 1'b1;
            xbar_valid[o]              = 1'b1;
            xbar_sel[o*IDX_W +: IDX_W] = own;
            if (bus.i_req_tail[own]) begin
              state_d[o]  = StIdle;
              rr_ptr_d[o] = wrap_inc(own);
            end
          end
        end
        default: ;
      endcase
    end

    if (reset) begin
      grant      = '0;
      xbar_valid = '0;
      xbar_sel   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= StIdle;
        owner_q[o]  <= '0;
        rr_ptr_q[o] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o]  <= state_d[o];
        owner_q[o]  <= owner_d[o];
        rr_ptr_q[o] <= rr_ptr_d[o];
      end
      err_q <= err_d;
    end
  end

  assign bus.o_grant      = grant;
  assign bus.o_xbar_valid = xbar_valid;
  assign bus.o_xbar_sel   = xbar_sel;
  assign bus.o_proto_err  = err_q;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Directed bench for router_switch_allocator: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_router_switch_allocator;
  localparam int unsigned NP = 5;
  localparam int unsigned IW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  router_switch_allocator_if #(.NUM_PORTS(NP), .IDX_W(IW)) bus ();

  router_switch_allocator #(.NUM_PORTS(NP), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus.i_req_valid = '0;
    bus.i_req_dst   = '0;
    bus.i_req_head  = '0;
    bus.i_req_tail  = '0;
  endtask

  task automatic req(input int i, input int d, input logic h, input logic t);
    bus.i_req_valid[i]       = 1'b1;
    bus.i_req_dst[i*IW +: IW] = IW'(d);
    bus.i_req_head[i]        = h;
    bus.i_req_tail[i]        = t;
  endtask

  function automatic logic [IW-1:0] sel_of(input int o);
    return bus.o_xbar_sel[o*IW +: IW];
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    int rr_order [5];
    rr_order = '{4, 0, 3, 4, 0};
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.i_on_off = 5'h1f;
    idle_all();
    req(0, 2, 1'b1, 1'b1);

    // Reset forces combinational outputs low and clears state.
    nxt(); #1;
    chk("rst_grant", 32'(bus.o_grant), 32'h0);
    chk("rst_xv", 32'(bus.o_xbar_valid), 32'h0);
    chk("rst_locked", 32'(bus.o_locked), 32'h0);
    chk("rst_err", 32'(bus.o_proto_err), 32'h0);

    // Single-flit packet: same-cycle grant.
    nxt(); reset = 1'b0; #1;
    chk("sf_grant", 32'(bus.o_grant), 32'h01);
    chk("sf_xv", 32'(bus.o_xbar_valid), 32'h04);
    chk("sf_sel2", 32'(sel_of(2)), 32'd0);
    nxt(); idle_all(); #1;
    chk("sf_locked", 32'(bus.o_locked), 32'h0);
    chk("sf_idle_grant", 32'(bus.o_grant), 32'h0);
    // rr_ptr[2] is now 1: input 1 beats input 0, then pointer 2 wraps to input 0.
    nxt(); req(0, 2, 1'b1, 1'b1); req(1, 2, 1'b1, 1'b1); #1;
    chk("sf_rr1", 32'(bus.o_grant), 32'h02);
    nxt(); #1;
    chk("sf_rr2", 32'(bus.o_grant), 32'h01);

    // Out-of-range destination is ignored without error.
    nxt(); idle_all(); req(0, 7, 1'b1, 1'b1); #1;
    chk("oor_grant", 32'(bus.o_grant), 32'h0);
    chk("oor_xv", 32'(bus.o_xbar_valid), 32'h0);
    // Head blocked by on/off on an idle output.
    nxt(); idle_all(); bus.i_on_off = 5'h1b; req(0, 2, 1'b1, 1'b1); #1;
    chk("oor_err", 32'(bus.o_proto_err), 32'h0);
    chk("off_idle_grant", 32'(bus.o_grant), 32'h0);
    bus.i_on_off = 5'h1f;

    // Wormhole: input 1 owns output 4 for three flits, input 3 waits.
    nxt(); idle_all(); req(1, 4, 1'b1, 1'b0); req(3, 4, 1'b1, 1'b1); #1;
    chk("wh_c1_grant", 32'(bus.o_grant), 32'h02);
    chk("wh_c1_sel4", 32'(sel_of(4)), 32'd1);
    chk("wh_c1_locked", 32'(bus.o_locked), 32'h00);
    nxt(); req(1, 4, 1'b0, 1'b0); #1;
    chk("wh_c2_grant", 32'(bus.o_grant), 32'h02);
    chk("wh_c2_locked", 32'(bus.o_locked), 32'h10);
    nxt(); req(1, 4, 1'b0, 1'b1); #1;
    chk("wh_c3_grant", 32'(bus.o_grant), 32'h02);
    chk("wh_c3_locked", 32'(bus.o_locked), 32'h10);
    nxt(); idle_all(); req(3, 4, 1'b1, 1'b1); #1;
    chk("wh_c4_grant", 32'(bus.o_grant), 32'h08);
    chk("wh_c4_sel4", 32'(sel_of(4)), 32'd3);
    chk("wh_c4_locked", 32'(bus.o_locked), 32'h00);
    nxt(); idle_all(); #1;
    chk("wh_err", 32'(bus.o_proto_err), 32'h0);

    // Round-robin wrap on output 1: first move rr_ptr[1] to 4.
    nxt(); req(3, 1, 1'b1, 1'b1); #1;
    chk("rr_setup", 32'(bus.o_grant), 32'h08);
    for (int k = 0; k < 5; k++) begin
      nxt(); idle_all();
      req(0, 1, 1'b1, 1'b1); req(3, 1, 1'b1, 1'b1); req(4, 1, 1'b1, 1'b1); #1;
      chk($sformatf("rr_grant%0d", k), 32'(bus.o_grant), 32'h1 << rr_order[k]);
      chk($sformatf("rr_sel%0d", k), 32'(sel_of(1)), 32'(rr_order[k]));
    end

    // On/off stall: 4-flit packet from input 2 to output 0 over 7 cycles.
    nxt(); idle_all(); req(2, 0, 1'b1, 1'b0); #1;
    chk("st_f1", 32'(bus.o_grant), 32'h04);
    chk("st_f1_xv", 32'(bus.o_xbar_valid), 32'h01);
    nxt(); req(2, 0, 1'b0, 1'b0); #1;
    chk("st_f2", 32'(bus.o_grant), 32'h04);
    chk("st_f2_locked", 32'(bus.o_locked), 32'h01);
    for (int k = 0; k < 3; k++) begin
      nxt(); bus.i_on_off = 5'h1e; #1;
      chk($sformatf("st_stall_grant%0d", k), 32'(bus.o_grant), 32'h0);
      chk($sformatf("st_stall_xv%0d", k), 32'(bus.o_xbar_valid), 32'h0);
      chk($sformatf("st_stall_sel%0d", k), 32'(sel_of(0)), 32'd0);
      chk($sformatf("st_stall_lock%0d", k), 32'(bus.o_locked), 32'h01);
    end
    nxt(); bus.i_on_off = 5'h1f; #1;
    chk("st_f3", 32'(bus.o_grant), 32'h04);
    nxt(); req(2, 0, 1'b0, 1'b1); #1;
    chk("st_f4", 32'(bus.o_grant), 32'h04);
    chk("st_f4_locked", 32'(bus.o_locked), 32'h01);
    nxt(); idle_all(); #1;
    chk("st_done_locked", 32'(bus.o_locked), 32'h00);

    // Body flit to an idle output: no grant, sticky error.
    nxt(); req(1, 3, 1'b0, 1'b0); #1;
    chk("pe_grant", 32'(bus.o_grant), 32'h0);
    chk("pe_err_same", 32'(bus.o_proto_err), 32'h0);
    nxt(); idle_all(); #1;
    chk("pe_err_set", 32'(bus.o_proto_err), 32'h1);
    nxt(); #1;
    chk("pe_err_sticky", 32'(bus.o_proto_err), 32'h1);

    // Reset mid-packet drops the lock; the leftover body flit then errors.
    nxt(); req(2, 3, 1'b1, 1'b0); #1;
    chk("mr_head", 32'(bus.o_grant), 32'h04);
    nxt(); req(2, 3, 1'b0, 1'b0); #1;
    chk("mr_locked", 32'(bus.o_locked), 32'h08);
    chk("mr_body", 32'(bus.o_grant), 32'h04);
    nxt(); reset = 1'b1; #1;
    chk("mr_rst_grant", 32'(bus.o_grant), 32'h0);
    nxt(); reset = 1'b0; #1;
    chk("mr_locked_clr", 32'(bus.o_locked), 32'h0);
    chk("mr_err_clr", 32'(bus.o_proto_err), 32'h0);
    chk("mr_body_grant", 32'(bus.o_grant), 32'h0);
    nxt(); idle_all(); #1;
    chk("mr_err_set", 32'(bus.o_proto_err), 32'h1);
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0; #1;
    chk("mr_err_reclr", 32'(bus.o_proto_err), 32'h0);

    // All five outputs granted in parallel.
    nxt();
    req(0, 1, 1'b1, 1'b1); req(1, 2, 1'b1, 1'b1); req(2, 3, 1'b1, 1'b1);
    req(3, 4, 1'b1, 1'b1); req(4, 0, 1'b1, 1'b1); #1;
    chk("par_grant", 32'(bus.o_grant), 32'h1f);
    chk("par_xv", 32'(bus.o_xbar_valid), 32'h1f);
    chk("par_sel", 32'(bus.o_xbar_sel), 32'(15'b011_010_001_000_100));
    nxt(); idle_all(); #1;
    chk("par_locked", 32'(bus.o_locked), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
